// File: rtl/lcd_nios2_qsys_0_oci_dct_packer.sv
// OCI data-compression-trace packer: folds 2-bit trace tokens into a 30-bit buffer and
// hands full or flushed buffers to the trace sink, then sequences the end-of-test flags.
module lcd_nios2_qsys_0_oci_dct_packer #(
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tok_valid,
  input  logic [1:0]        tok_data,
  output logic              tok_ready,
  input  logic              flush,
  input  logic              end_req,
  output logic [29:0]       dct_buffer,
  output logic [3:0]        dct_count,
  output logic              word_valid,
  output logic [29:0]       word_data,
  output logic [3:0]        word_count,
  input  logic              word_ready,
  output logic              test_ending,
  output logic              test_has_ended,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {StFill, StEnding, StEnded} state_e;

  localparam logic [DROP_W-1:0] DropMax = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DropOne = {{(DROP_W-1){1'b0}}, 1'b1};

  logic [1:0]        sync_q;
  logic              rst_n_int;
  state_e            state_q, state_d;
  logic [29:0]       buf_q, buf_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              wv_q, wv_d;
  logic [29:0]       wd_q, wd_d;
  logic [3:0]        wc_q, wc_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              accept;
  logic              slot_free;
  logic              flush_req;
  logic [29:0]       pack_buf;
  logic [3:0]        pack_cnt;

  // Reset asserts asynchronously through the synchroniser, releases two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = sync_q[1];

  // Depends only on registered state so the sink's ready never reaches the token side.
  assign tok_ready = rst_n_int && (state_q == StFill) && !((cnt_q == 4'd14) && wv_q);
  assign accept    = tok_valid && tok_ready;
  assign slot_free = !wv_q || word_ready;
  assign flush_req = flush || pend_q || (state_q == StEnding);
  assign pack_buf  = {buf_q[27:0], tok_data};
  assign pack_cnt  = cnt_q + 4'd1;

  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    wv_d   = wv_q;
    wd_d   = wd_q;
    wc_d   = wc_q;

    if (wv_q && word_ready) begin
      wv_d = 1'b0;
    end

    if (accept && (cnt_q == 4'd14)) begin
      // Fifteenth token: full word wins over any flush request.
      wv_d   = 1'b1;
      wd_d   = pack_buf;
      wc_d   = 4'd15;
      buf_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (flush_req && (cnt_q != 4'd0)) begin
      if (slot_free) begin
        wv_d   = 1'b1;
        wd_d   = accept ? pack_buf : buf_q;
        wc_d   = accept ? pack_cnt : cnt_q;
        buf_d  = '0;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else begin
        pend_d = (state_q == StFill);
        if (accept) begin
          buf_d = pack_buf;
          cnt_d = pack_cnt;
        end
      end
    end else begin
      pend_d = 1'b0;
      if (accept) begin
        buf_d = pack_buf;
        cnt_d = pack_cnt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: begin
        if (end_req) begin
          state_d = StEnding;
        end
      end
      StEnding: begin
        if (!wv_q && (cnt_q == 4'd0)) begin
          state_d = StEnded;
        end
      end
      StEnded: state_d = StEnded;
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (tok_valid && !tok_ready && (drop_q != DropMax)) begin
      drop_d = drop_q + DropOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= StFill;
      buf_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      wv_q    <= 1'b0;
      wd_q    <= '0;
      wc_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wv_q    <= wv_d;
      wd_q    <= wd_d;
      wc_q    <= wc_d;
      drop_q  <= drop_d;
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign word_valid     = wv_q;
  assign word_data      = wd_q;
  assign word_count     = wc_q;
  assign test_ending    = (state_q == StEnding);
  assign test_has_ended = (state_q == StEnded);
  assign drop_cnt       = drop_q;

endmodule
